// File: rtl/reg_file_2r1w_pkg.sv
// reg_file_2r1w_pkg: shared defaults and address helper for the register file
package reg_file_2r1w_pkg;
  localparam int RF_WIDTH_DEFAULT    = 32;
  localparam int RF_NUM_REGS_DEFAULT = 32;
  localparam int RF_ZERO_REG_DEFAULT = 1;
  localparam int RF_BYPASS_DEFAULT   = 1;
  function automatic logic in_range(input int unsigned addr, input int unsigned n);
    return addr < n;
  endfunction
endpackage

// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: write port, two read ports and written flags of the register file
interface reg_file_2r1w_if #(
  parameter int WIDTH    = reg_file_2r1w_pkg::RF_WIDTH_DEFAULT,
  parameter int NUM_REGS = reg_file_2r1w_pkg::RF_NUM_REGS_DEFAULT
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic [NUM_REGS-1:0] written;
  modport master (output we, waddr, wdata, raddr_a, raddr_b, input rdata_a, rdata_b, written);
  modport slave  (input we, waddr, wdata, raddr_a, raddr_b, output rdata_a, rdata_b, written);
endinterface

// File: rtl/reg_file_2r1w_rf_entry.sv
// rf_entry: one load-enabled register with synchronous clear
module rf_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  always_comb q_d = rst ? '0 : load_i ? d_i : q_q;
  always_ff @(posedge clk) q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: NUM_REGS x WIDTH register file, two combinational reads, one write
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_DEFAULT,
  parameter int NUM_REGS = RF_NUM_REGS_DEFAULT,
  parameter int ZERO_REG = RF_ZERO_REG_DEFAULT,
  parameter int BYPASS   = RF_BYPASS_DEFAULT
) (
  input logic clk,
  input logic rst,
  reg_file_2r1w_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [NUM_REGS-1:0] load;
  logic [NUM_REGS-1:0] written_q;
  logic [NUM_REGS-1:0] written_d;
  logic                wvalid;
  logic                wr_en;
  logic                byp_a;
  logic                byp_b;
  // entry 0 is excluded from writes when hardwired to zero
  always_comb begin
    wvalid = in_range(32'(bus.waddr), NUM_REGS) && !(ZERO_REG != 0 && bus.waddr == '0);
    wr_en  = bus.we && !rst && wvalid;
    byp_a  = BYPASS != 0 && wr_en && bus.waddr == bus.raddr_a;
    byp_b  = BYPASS != 0 && wr_en && bus.waddr == bus.raddr_b;
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    assign load[i] = wr_en && bus.waddr == ADDR_W'(i);
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign q[i] = '0;
    end else begin : g_reg
      rf_entry #(.WIDTH(WIDTH)) u_entry (
        .clk    (clk),
        .rst    (rst),
        .load_i (load[i]),
        .d_i    (bus.wdata),
        .q_o    (q[i])
      );
    end
  end
  always_comb written_d = rst ? '0 : written_q | load;
  always_ff @(posedge clk) written_q <= written_d;
  always_comb begin
    bus.rdata_a = byp_a ? bus.wdata : in_range(32'(bus.raddr_a), NUM_REGS) ? q[bus.raddr_a] : '0;
    bus.rdata_b = byp_b ? bus.wdata : in_range(32'(bus.raddr_b), NUM_REGS) ? q[bus.raddr_b] : '0;
  end
  assign bus.written = written_q;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed checks of three builds (default, no bypass, no zero reg)
module tb_reg_file_2r1w;
  logic clk = 0;
  logic rst = 1;
  logic we = 0;
  logic [2:0] waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [7:0] wdata = 0;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  reg_file_2r1w_if #(.WIDTH(8), .NUM_REGS(6)) bus_d ();
  reg_file_2r1w_if #(.WIDTH(8), .NUM_REGS(6)) bus_n ();
  reg_file_2r1w_if #(.WIDTH(8), .NUM_REGS(6)) bus_z ();
  assign bus_d.we = we;  assign bus_d.waddr = waddr;  assign bus_d.wdata = wdata;
  assign bus_d.raddr_a = raddr_a;  assign bus_d.raddr_b = raddr_b;
  assign bus_n.we = we;  assign bus_n.waddr = waddr;  assign bus_n.wdata = wdata;
  assign bus_n.raddr_a = raddr_a;  assign bus_n.raddr_b = raddr_b;
  assign bus_z.we = we;  assign bus_z.waddr = waddr;  assign bus_z.wdata = wdata;
  assign bus_z.raddr_a = raddr_a;  assign bus_z.raddr_b = raddr_b;
  reg_file_2r1w #(.WIDTH(8), .NUM_REGS(6), .ZERO_REG(1), .BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus_d));
  reg_file_2r1w #(.WIDTH(8), .NUM_REGS(6), .ZERO_REG(1), .BYPASS(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));
  reg_file_2r1w #(.WIDTH(8), .NUM_REGS(6), .ZERO_REG(0), .BYPASS(1)) dut_z (.clk(clk), .rst(rst), .bus(bus_z));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; we = 1; waddr = 3; wdata = 8'hAA; raddr_a = 3; raddr_b = 5;
    tick(); tick();
    vecs++; if (bus_d.rdata_a !== 8'h00) begin errs++; $display("FAIL reset_rda got %h exp 00", bus_d.rdata_a); end
    vecs++; if (bus_d.rdata_b !== 8'h00) begin errs++; $display("FAIL reset_rdb got %h exp 00", bus_d.rdata_b); end
    vecs++; if (bus_d.written !== 6'b0) begin errs++; $display("FAIL reset_written got %b exp 000000", bus_d.written); end
    vecs++; if (bus_z.written !== 6'b0) begin errs++; $display("FAIL reset_written_z got %b exp 000000", bus_z.written); end
    rst = 0; we = 0;
  endtask

  task automatic test_write();
    we = 1; waddr = 3; wdata = 8'h5A; tick();
    waddr = 5; wdata = 8'hC3; tick();
    we = 0; raddr_a = 3; raddr_b = 5; #1;
    vecs++; if (bus_d.rdata_a !== 8'h5A) begin errs++; $display("FAIL write_rda got %h exp 5a", bus_d.rdata_a); end
    vecs++; if (bus_d.rdata_b !== 8'hC3) begin errs++; $display("FAIL write_rdb got %h exp c3", bus_d.rdata_b); end
    vecs++; if (bus_d.written !== 6'b101000) begin errs++; $display("FAIL write_written got %b exp 101000", bus_d.written); end
    vecs++; if (bus_n.rdata_a !== 8'h5A) begin errs++; $display("FAIL write_rda_n got %h exp 5a", bus_n.rdata_a); end
  endtask

  task automatic test_invalid();
    we = 1; waddr = 0; wdata = 8'hFF; tick();
    waddr = 7; wdata = 8'h11; tick();
    we = 0; raddr_a = 0; raddr_b = 7; #1;
    vecs++; if (bus_d.rdata_a !== 8'h00) begin errs++; $display("FAIL inv_zero got %h exp 00", bus_d.rdata_a); end
    vecs++; if (bus_d.rdata_b !== 8'h00) begin errs++; $display("FAIL inv_oor got %h exp 00", bus_d.rdata_b); end
    vecs++; if (bus_d.written !== 6'b101000) begin errs++; $display("FAIL inv_written got %b exp 101000", bus_d.written); end
    vecs++; if (bus_z.rdata_a !== 8'hFF) begin errs++; $display("FAIL inv_zero_z got %h exp ff", bus_z.rdata_a); end
    vecs++; if (bus_z.written !== 6'b101001) begin errs++; $display("FAIL inv_written_z got %b exp 101001", bus_z.written); end
    we = 1; waddr = 7; wdata = 8'h11; raddr_a = 7; #1;
    vecs++; if (bus_d.rdata_a !== 8'h00) begin errs++; $display("FAIL inv_oor_bypass got %h exp 00", bus_d.rdata_a); end
    waddr = 0; wdata = 8'hEE; raddr_a = 0; #1;
    vecs++; if (bus_d.rdata_a !== 8'h00) begin errs++; $display("FAIL inv_zero_bypass got %h exp 00", bus_d.rdata_a); end
    we = 0;
  endtask

  task automatic test_bypass();
    we = 1; waddr = 2; wdata = 8'h77; raddr_a = 2; raddr_b = 2; #1;
    vecs++; if (bus_d.rdata_a !== 8'h77) begin errs++; $display("FAIL byp_rda got %h exp 77", bus_d.rdata_a); end
    vecs++; if (bus_d.rdata_b !== 8'h77) begin errs++; $display("FAIL byp_rdb got %h exp 77", bus_d.rdata_b); end
    vecs++; if (bus_n.rdata_a !== 8'h00) begin errs++; $display("FAIL nobyp_rda got %h exp 00", bus_n.rdata_a); end
    vecs++; if (bus_n.rdata_b !== 8'h00) begin errs++; $display("FAIL nobyp_rdb got %h exp 00", bus_n.rdata_b); end
    tick();
    we = 0; #1;
    vecs++; if (bus_n.rdata_a !== 8'h77) begin errs++; $display("FAIL nobyp_after got %h exp 77", bus_n.rdata_a); end
    we = 1; waddr = 3; wdata = 8'h12; raddr_a = 3; raddr_b = 2; #1;
    vecs++; if (bus_d.rdata_a !== 8'h12) begin errs++; $display("FAIL byp_a_only got %h exp 12", bus_d.rdata_a); end
    vecs++; if (bus_d.rdata_b !== 8'h77) begin errs++; $display("FAIL byp_b_other got %h exp 77", bus_d.rdata_b); end
    we = 0; #1;
    vecs++; if (bus_d.rdata_a !== 8'h5A) begin errs++; $display("FAIL byp_we0 got %h exp 5a", bus_d.rdata_a); end
  endtask

  task automatic test_reset_mid();
    we = 1; waddr = 4; wdata = 8'h3C; tick();
    rst = 1; wdata = 8'h99; raddr_a = 4; raddr_b = 3; #1;
    vecs++; if (bus_d.rdata_a !== 8'h3C) begin errs++; $display("FAIL rstmid_nobyp got %h exp 3c", bus_d.rdata_a); end
    tick();
    rst = 0; we = 0; #1;
    vecs++; if (bus_d.rdata_a !== 8'h00) begin errs++; $display("FAIL rstmid_rda got %h exp 00", bus_d.rdata_a); end
    vecs++; if (bus_d.rdata_b !== 8'h00) begin errs++; $display("FAIL rstmid_rdb got %h exp 00", bus_d.rdata_b); end
    vecs++; if (bus_d.written !== 6'b0) begin errs++; $display("FAIL rstmid_written got %b exp 000000", bus_d.written); end
  endtask

  task automatic test_zero_off();
    we = 1; waddr = 0; wdata = 8'h42; raddr_a = 0; raddr_b = 1; #1;
    vecs++; if (bus_z.rdata_a !== 8'h42) begin errs++; $display("FAIL zoff_byp got %h exp 42", bus_z.rdata_a); end
    vecs++; if (bus_d.rdata_a !== 8'h00) begin errs++; $display("FAIL zon_byp got %h exp 00", bus_d.rdata_a); end
    tick();
    we = 0; #1;
    vecs++; if (bus_z.rdata_a !== 8'h42) begin errs++; $display("FAIL zoff_rd got %h exp 42", bus_z.rdata_a); end
    vecs++; if (bus_z.written !== 6'b000001) begin errs++; $display("FAIL zoff_written got %b exp 000001", bus_z.written); end
    vecs++; if (bus_d.written !== 6'b000000) begin errs++; $display("FAIL zon_written got %b exp 000000", bus_d.written); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_invalid();
    test_bypass();
    test_reset_mid();
    test_zero_off();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
